// File: rtl/tdm_demux_8.sv
// Rebuilds 8 parallel channel bits from a sync-marked 1-bit TDM slot stream; optional TDM_PARITY_EN adds an even-parity 9th slot.
// Latency: y/frame_valid update on the edge that samples the final slot (1 cycle after the last bit is presented).
// Backpressure: none; input is paced by en, and alignment is held across en=0 gaps.
module tdm_demux_8 #(
    parameter logic [7:0] INIT_Y = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic       sync,
    output logic [7:0] y,
    output logic       frame_valid,
    output logic [2:0] slot,
    output logic       locked,
    output logic       sync_err
);

`ifdef TDM_PARITY_EN
    localparam int          SW       = 4;
    localparam int          SHW      = 8;
    localparam logic [SW-1:0] LAST_SLOT = 4'd8;
`else
    localparam int          SW       = 3;
    localparam int          SHW      = 7;
    localparam logic [SW-1:0] LAST_SLOT = 3'd7;
`endif

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [SHW-1:0]  shadow_q, shadow_d;
    logic [7:0]      y_d;
    logic            frame_valid_d;
    logic            sync_err_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        y_d           = y;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        if (en) begin
            if (state_q == HUNT) begin
                if (sync) begin
                    shadow_d[0] = din;
                    slot_d      = SW'(1);
                    state_d     = RUN;
                end
            end else if (sync) begin
                // An early sync drops the partial frame and restarts at slot 0.
                sync_err_d  = (slot_q != '0);
                shadow_d[0] = din;
                slot_d      = SW'(1);
            end else if (slot_q == '0) begin
                sync_err_d = 1'b1;
                state_d    = HUNT;
            end else if (slot_q == LAST_SLOT) begin
                slot_d = '0;
`ifdef TDM_PARITY_EN
                if ((^shadow_q ^ din) == 1'b0) begin
                    y_d           = shadow_q;
                    frame_valid_d = 1'b1;
                end else begin
                    sync_err_d = 1'b1;
                end
`else
                y_d           = {din, shadow_q[6:0]};
                frame_valid_d = 1'b1;
`endif
            end else begin
                shadow_d[slot_q[2:0]] = din;
                slot_d                = slot_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            shadow_q    <= '0;
            y           <= INIT_Y;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            y           <= y_d;
            frame_valid <= frame_valid_d;
            sync_err    <= sync_err_d;
        end
    end

    assign slot   = slot_q[2:0];
    assign locked = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux_8.sv
// Self-checking bench for tdm_demux_8: directed scenarios plus randomized slot streams against a frame-level reference model.
module tb_tdm_demux_8;

    localparam logic [7:0] INIT_Y = 8'h00;
`ifdef TDM_PARITY_EN
    localparam int NSLOT = 9;
`else
    localparam int NSLOT = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] y;
    logic       frame_valid;
    logic [2:0] slot;
    logic       locked;
    logic       sync_err;

    tdm_demux_8 #(.INIT_Y(INIT_Y)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .y(y), .frame_valid(frame_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: collected bits of the frame in progress; its size is the next slot index.
    bit         m_locked;
    bit         m_bits[$];
    logic [7:0] m_y;
    bit         m_fv;
    bit         m_se;

    function automatic void model_reset();
        m_locked = 1'b0;
        m_bits.delete();
        m_y  = INIT_Y;
        m_fv = 1'b0;
        m_se = 1'b0;
    endfunction

    function automatic void model_step(bit e, bit s, bit d);
        logic [7:0] w;
        bit         par;
        m_fv = 1'b0;
        m_se = 1'b0;
        if (!e) return;
        if (!m_locked) begin
            if (s) begin
                m_bits   = '{d};
                m_locked = 1'b1;
            end
        end else if (s) begin
            if (m_bits.size() != 0) m_se = 1'b1;
            m_bits = '{d};
        end else if (m_bits.size() == 0) begin
            m_se     = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_bits.push_back(d);
            if (m_bits.size() == NSLOT) begin
                w   = 8'h00;
                par = 1'b0;
                for (int i = 0; i < NSLOT; i++) begin
                    par ^= m_bits[i];
                    if (i < 8) w[i] = m_bits[i];
                end
                if (NSLOT == 8 || par == 1'b0) begin
                    m_y  = w;
                    m_fv = 1'b1;
                end else begin
                    m_se = 1'b1;
                end
                m_bits.delete();
            end
        end
    endfunction

    function automatic bit slot_bit(logic [7:0] v, int k);
        if (k < 8) return v[k];
        return ^v;
    endfunction

    // Called at a negedge; returns at the following negedge with the model advanced.
    task automatic step(input bit e, input bit s, input bit d);
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        model_step(e, s, d);
        @(negedge clk);
    endtask

    task automatic send_slots(input logic [7:0] v, input int from, input int to);
        for (int k = from; k <= to; k++) step(1'b1, k == 0, slot_bit(v, k));
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({y, locked, slot, frame_valid, sync_err} !== {INIT_Y, 1'b0, 3'd0, 1'b0, 1'b0})
            $display("FAIL reset_state: y=%h locked=%b slot=%0d fv=%b se=%b, expected y=%h locked=0 slot=0 fv=0 se=0",
                     y, locked, slot, frame_valid, sync_err, INIT_Y);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lock();
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (locked !== 1'b1 || slot !== 3'd1)
            $display("FAIL lock_first_edge: locked=%b slot=%0d, expected locked=1 slot=1", locked, slot);
        else n_pass++;
        send_slots(8'h81, 1, NSLOT - 2);
        n_checks++;
        if (frame_valid !== 1'b0 || y !== INIT_Y)
            $display("FAIL lock_no_early_publish: fv=%b y=%h, expected fv=0 y=%h", frame_valid, y, INIT_Y);
        else n_pass++;
        step(1'b1, 1'b0, slot_bit(8'h81, NSLOT - 1));
        n_checks++;
        if (y !== 8'h81 || frame_valid !== 1'b1 || sync_err !== 1'b0)
            $display("FAIL lock_frame: y=%h fv=%b se=%b, expected y=81 fv=1 se=0", y, frame_valid, sync_err);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (frame_valid !== 1'b0 || y !== 8'h81)
            $display("FAIL lock_fv_one_cycle: fv=%b y=%h, expected fv=0 y=81", frame_valid, y);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int fv_at;
        bit se_seen;
        fv_at   = -1;
        se_seen = 1'b0;
        send_slots(8'h81, 0, NSLOT - 1);
        for (int k = 0; k < NSLOT; k++) begin
            step(1'b1, k == 0, slot_bit(8'h40, k));
            if (frame_valid === 1'b1 && fv_at < 0) fv_at = k + 1;
            if (sync_err !== 1'b0) se_seen = 1'b1;
        end
        n_checks++;
        if (fv_at != NSLOT || y !== 8'h40 || se_seen)
            $display("FAIL back_to_back: fv after %0d cycles y=%h se_seen=%b, expected %0d cycles y=40 se_seen=0",
                     fv_at, y, se_seen, NSLOT);
        else n_pass++;
    endtask

    task automatic test_en_gaps();
        bit held;
        held = 1'b1;
        send_slots(8'hA5, 0, 3);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b1, 1'b1);
            if (slot !== 3'd4 || frame_valid !== 1'b0 || sync_err !== 1'b0 || locked !== 1'b1) held = 1'b0;
        end
        n_checks++;
        if (!held) $display("FAIL en_gap_hold: slot=%0d fv=%b se=%b, expected slot=4 fv=0 se=0", slot, frame_valid, sync_err);
        else n_pass++;
        send_slots(8'hA5, 4, NSLOT - 1);
        n_checks++;
        if (y !== 8'hA5 || frame_valid !== 1'b1)
            $display("FAIL en_gap_frame: y=%h fv=%b, expected y=a5 fv=1", y, frame_valid);
        else n_pass++;
    endtask

    task automatic test_early_sync();
        send_slots(8'h3C, 0, 4);
        step(1'b1, 1'b1, slot_bit(8'h3C, 0));
        n_checks++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || y !== 8'hA5 || slot !== 3'd1 || locked !== 1'b1)
            $display("FAIL early_sync: se=%b fv=%b y=%h slot=%0d locked=%b, expected se=1 fv=0 y=a5 slot=1 locked=1",
                     sync_err, frame_valid, y, slot, locked);
        else n_pass++;
        send_slots(8'h3C, 1, NSLOT - 1);
        n_checks++;
        if (y !== 8'h3C || frame_valid !== 1'b1 || sync_err !== 1'b0)
            $display("FAIL early_sync_recover: y=%h fv=%b se=%b, expected y=3c fv=1 se=0", y, frame_valid, sync_err);
        else n_pass++;
    endtask

    task automatic test_missing_sync();
        bit ignored;
        ignored = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 3'd0 || y !== 8'h3C)
            $display("FAIL missing_sync: se=%b locked=%b slot=%0d y=%h, expected se=1 locked=0 slot=0 y=3c",
                     sync_err, locked, slot, y);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, k[0]);
            if (locked !== 1'b0 || slot !== 3'd0 || frame_valid !== 1'b0 || sync_err !== 1'b0) ignored = 1'b0;
        end
        n_checks++;
        if (!ignored) $display("FAIL hunt_ignore: locked=%b slot=%0d fv=%b se=%b, expected all 0", locked, slot, frame_valid, sync_err);
        else n_pass++;
        send_slots(8'h5A, 0, NSLOT - 1);
        n_checks++;
        if (y !== 8'h5A || frame_valid !== 1'b1 || locked !== 1'b1)
            $display("FAIL relock: y=%h fv=%b locked=%b, expected y=5a fv=1 locked=1", y, frame_valid, locked);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        send_slots(8'h77, 0, 3);
        n_checks++;
        if (slot !== 3'd4) $display("FAIL pre_reset_slot: slot=%0d, expected 4", slot);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (y !== INIT_Y || slot !== 3'd0 || locked !== 1'b0 || frame_valid !== 1'b0)
            $display("FAIL async_reset: y=%h slot=%0d locked=%b fv=%b, expected y=%h slot=0 locked=0 fv=0",
                     y, slot, locked, frame_valid, INIT_Y);
        else n_pass++;
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (locked !== 1'b0 || slot !== 3'd0 || sync_err !== 1'b0)
            $display("FAIL post_reset_hunt: locked=%b slot=%0d se=%b, expected 0 0 0", locked, slot, sync_err);
        else n_pass++;
    endtask

`ifdef TDM_PARITY_EN
    task automatic test_parity();
        send_slots(8'h81, 0, 7);
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1 || frame_valid !== 1'b0 || y !== INIT_Y || locked !== 1'b1 || slot !== 3'd0)
            $display("FAIL parity_bad: se=%b fv=%b y=%h locked=%b slot=%0d, expected se=1 fv=0 y=%h locked=1 slot=0",
                     sync_err, frame_valid, y, locked, slot, INIT_Y);
        else n_pass++;
        send_slots(8'h81, 0, 7);
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (y !== 8'h81 || frame_valid !== 1'b1 || sync_err !== 1'b0)
            $display("FAIL parity_good: y=%h fv=%b se=%b, expected y=81 fv=1 se=0", y, frame_valid, sync_err);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [14:0] got, exp;
        for (int i = 0; i < 800; i++) begin
            bit e, s, d;
            e = ($urandom_range(0, 3) != 0);
            d = $urandom_range(0, 1);
            if (m_bits.size() == 0) s = ($urandom_range(0, 9) != 0);
            else                    s = ($urandom_range(0, 24) == 0);
            step(e, s, d);
            exp = {m_y, m_fv, 3'(m_bits.size()), m_locked, m_se};
            got = {y, frame_valid, slot, locked, sync_err};
            n_checks++;
            if (got !== exp)
                $display("FAIL random[%0d]: {y,fv,slot,locked,se}=%h, expected %h", i, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_back_to_back();
        test_en_gaps();
        test_early_sync();
        test_missing_sync();
        test_async_reset();
`ifdef TDM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tdm_demux_8.md
# tdm_demux_8

Receive-side time-division demultiplexer for the 8:1 mux datapath. It takes the single-bit slot stream produced by cycling an 8:1 mux select through 000..111, with a frame marker on slot 0. It rebuilds the eight parallel channel bits and presents each complete frame on a registered 8-bit output with a one-cycle valid strobe. A slot counter and a hunt/run state machine track frame alignment and report misaligned sync.

## Interface
Parameters:
- INIT_Y, default 8'h00: reset and hunt value of y.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  slot strobe; din and sync are sampled only when en=1.
- din  input  1  serial slot bit. Slot k carries mux input i(k+1) (select k).
- sync  input  1  frame marker; qualified by en; marks slot 0.
- y  output  8  last complete frame; y[k] = slot k bit.
- frame_valid  output  1  one-cycle pulse when y updates.
- slot  output  3  index of the next slot expected.
- locked  output  1  1 in RUN state.
- sync_err  output  1  one-cycle pulse on alignment fault.

## Operation
- States: HUNT (reset state), RUN.
- HUNT:
  - en=1 with sync=0 is ignored.
  - en=1 with sync=1: din is written to shadow[0], slot becomes 1, and the state moves to RUN.
- RUN, on each en=1 cycle:
  - sync=0 and slot≠0: shadow[slot] ← din, then slot ← slot+1.
  - Capturing slot 7 (without TDM_PARITY_EN): y ← {din, shadow[6:0]}, frame_valid pulses, and slot wraps to 0.
  - sync=1 and slot=0: normal frame start. shadow[0] ← din, slot ← 1.
  - sync=1 and slot≠0 (early sync): sync_err pulses and the partial frame is discarded (y is not updated). The bit is taken as the new slot 0: shadow[0] ← din, slot ← 1. The state stays RUN.
  - sync=0 and slot=0 (missing sync): sync_err pulses, the state goes to HUNT, slot ← 0, and the bit is dropped.
- en=0: no state, slot or shadow change; frame_valid and sync_err are 0.
- Shadow bits are not cleared between frames. Every bit of a published y comes from the current frame.
- Reset, asynchronous and taking effect mid-frame if asserted then:
  - y=INIT_Y
  - frame_valid=0
  - sync_err=0
  - slot=0
  - locked=0
  - state HUNT
  - shadow=0
- On entry to HUNT after a fault, y holds its last value; it is not reset to INIT_Y.

## Timing
- All outputs are registered.
- y and frame_valid change on the same clk edge that samples the final slot (slot 7, or the parity slot). Data therefore appears 1 cycle after the last bit is presented.
- Minimum frame period with en held high:
  - 8 cycles without TDM_PARITY_EN.
  - 9 cycles with it.
- frame_valid and sync_err are never high for more than one cycle per event.
- frame_valid and sync_err are mutually exclusive in a given cycle.
- locked changes on the edge that performs the state transition.
- slot is valid every cycle and reflects the position for the next en.
- en may be low for any number of cycles between slots; alignment is held.

## Configuration
- TDM_PARITY_EN:
  - Defined:
    - Each frame gains a 9th slot (index 8; slot widens internally to 4 bits, and the port shows slot[2:0] with the overflow bit internal) carrying even parity over the 8 data bits.
    - On the parity slot, if ^{shadow} ^ din == 0: y updates and frame_valid pulses.
    - Otherwise y is held and sync_err pulses; the state stays RUN.
    - Slot wraps to 0 after the parity slot.
  - Undefined: frames are 8 slots and there is no parity check.

## Test plan
- Reset then lock: with rst high, check y=8'h00, locked=0. Release, drive en=1 and sync on slot 0, stream bits 1,0,0,0,0,0,0,1 -> on the 8th edge y=8'h81 with frame_valid high for one cycle, and locked=1 from the 1st edge.
- Back-to-back frames: send 8'h81, then the frame with only slot 6 set -> y=8'h40 exactly 8 cycles after the first frame_valid, with no sync_err.
- en gaps: insert 3 idle en=0 cycles between slots 3 and 4 of 8'hA5 -> y=8'hA5 and slot held at 4 during the gap.
- Early sync: assert sync at slot 5 -> sync_err pulse, y unchanged, slot=1, then a complete frame 8'h3C is received correctly.
- Missing sync: en=1 with sync=0 at slot 0 -> sync_err, locked=0. Further data is ignored until sync is asserted.
- Async reset mid-frame (rst at slot 4) -> immediately y=8'h00, slot=0, locked=0. With TDM_PARITY_EN, frame 8'h81 with parity 1 -> sync_err and no update; with parity 0 -> y=8'h81.
